// File: rtl/lsu_mem_stage.sv
// Load/store unit for the MEM stage: issues word-aligned byte-lane memory
// accesses, splits word-straddling accesses into two transactions, and
// aligns/extends load data for writeback.
module lsu_mem_stage #(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_load,
    input  logic             req_store,
    input  logic [1:0]       req_size,
    input  logic             req_signed,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    output logic             do_read,
    output logic [31:0]      mem_addr,
    output logic [3:0]       do_write_byte,
    output logic [31:0]      mem_write_data,
    input  logic [31:0]      mem_read_data,
    output logic             rsp_valid,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag
);

    typedef enum logic [2:0] {StIdle, StLdWait, StLd1, StLd2, StSt2} state_e;

    state_e           state_q, state_d;
    logic [31:0]      base_q, base_d;
    logic [1:0]       off_q, off_d;
    logic [1:0]       size_q, size_d;
    logic             sgn_q, sgn_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      hold_q, hold_d;
    logic [3:0]       st_mask_q, st_mask_d;
    logic [31:0]      st_data_q, st_data_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

    logic [1:0]  off;
    logic [31:0] base;
    logic [2:0]  nbytes;
    logic [7:0]  byte_en;
    logic [7:0]  lane_mask;
    logic [63:0] wdata64;
    logic        split;
    logic [31:0] ld_raw;
    logic [31:0] ld_ext;

    assign off  = req_addr[1:0];
    assign base = {req_addr[31:2], 2'b00};

    // Decode request size into byte count and unshifted byte enables.
    always_comb begin
        nbytes  = 3'd4;
        byte_en = 8'h0f;
        unique case (req_size)
            2'd0: begin
                nbytes  = 3'd1;
                byte_en = 8'h01;
            end
            2'd1: begin
                nbytes  = 3'd2;
                byte_en = 8'h03;
            end
            default: begin
                nbytes  = 3'd4;
                byte_en = 8'h0f;
            end
        endcase
    end

    // Lanes [3:0] go to word A, lanes [7:4] spill into word A+4.
    assign lane_mask = byte_en << off;
    assign wdata64   = {32'b0, req_wdata} << {off, 3'b000};
    assign split     = ({1'b0, off} + nbytes) > 3'd4;

    // Right-justify load bytes; in LD2 the held low bytes are merged with the
    // second word, which starts at byte position 4-o (o is nonzero for splits).
    always_comb begin
        if (state_q == StLd2) begin
            ld_raw = hold_q | (mem_read_data << (6'd32 - {1'b0, off_q, 3'b000}));
        end else begin
            ld_raw = mem_read_data >> {off_q, 3'b000};
        end
        unique case (size_q)
            2'd0:    ld_ext = {{24{sgn_q & ld_raw[7]}}, ld_raw[7:0]};
            2'd1:    ld_ext = {{16{sgn_q & ld_raw[15]}}, ld_raw[15:0]};
            default: ld_ext = ld_raw;
        endcase
    end

    // Next-state, latching and memory-port drive.
    always_comb begin
        state_d        = state_q;
        base_d         = base_q;
        off_d          = off_q;
        size_d         = size_q;
        sgn_d          = sgn_q;
        tag_d          = tag_q;
        hold_d         = hold_q;
        st_mask_d      = st_mask_q;
        st_data_d      = st_data_q;
        rsp_valid_d    = 1'b0;
        rsp_data_d     = rsp_data_q;
        rsp_tag_d      = rsp_tag_q;
        req_ready      = 1'b0;
        do_read        = 1'b0;
        mem_addr       = 32'h0;
        do_write_byte  = 4'h0;
        mem_write_data = 32'h0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    base_d = base;
                    off_d  = off;
                    size_d = req_size;
                    sgn_d  = req_signed;
                    tag_d  = req_tag;
                    // Load wins when both flags are set.
                    if (req_load) begin
                        do_read  = 1'b1;
                        mem_addr = base;
                        state_d  = split ? StLd1 : StLdWait;
                    end else if (req_store) begin
                        mem_addr       = base;
                        do_write_byte  = lane_mask[3:0];
                        mem_write_data = wdata64[31:0];
                        if (split) begin
                            st_mask_d = lane_mask[7:4];
                            st_data_d = wdata64[63:32];
                            state_d   = StSt2;
                        end
                    end
                end
            end
            StLdWait, StLd2: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = ld_ext;
                rsp_tag_d   = tag_q;
                state_d     = StIdle;
            end
            StLd1: begin
                hold_d   = mem_read_data >> {off_q, 3'b000};
                do_read  = 1'b1;
                mem_addr = base_q + 32'd4;
                state_d  = StLd2;
            end
            StSt2: begin
                mem_addr       = base_q + 32'd4;
                do_write_byte  = st_mask_q;
                mem_write_data = st_data_q;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Keep the memory port quiet and refuse requests while in reset.
        if (!nreset) begin
            req_ready      = 1'b0;
            do_read        = 1'b0;
            mem_addr       = 32'h0;
            do_write_byte  = 4'h0;
            mem_write_data = 32'h0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= StIdle;
            base_q      <= 32'h0;
            off_q       <= 2'h0;
            size_q      <= 2'h0;
            sgn_q       <= 1'b0;
            tag_q       <= '0;
            hold_q      <= 32'h0;
            st_mask_q   <= 4'h0;
            st_data_q   <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            off_q       <= off_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            tag_q       <= tag_d;
            hold_q      <= hold_d;
            st_mask_q   <= st_mask_d;
            st_data_q   <= st_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_tag   = rsp_tag_q;

endmodule
